// File: rtl/wr_ingress_ctrl.sv
// rtl/wr_ingress_ctrl.sv - write-side FIFO ingress: 2-entry skid buffer, fill level, almost-full, stall counter
module wr_ingress_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 8,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  w_clk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_data,
  input  logic                  full,
  input  logic [PTR_WIDTH:0]    b_wptr,
  input  logic [PTR_WIDTH:0]    g_rptr_sync,
  output logic [PTR_WIDTH:0]    wr_level,
  output logic                  almost_full,
  output logic [15:0]           stall_cnt
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] AFULL_THRESH = (PTR_WIDTH+1)'(DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic [DATA_WIDTH-1:0] head_nxt, tail_nxt;
  logic                  push;
  logic                  pop;
  logic [PTR_WIDTH:0]    rbin;
  logic [PTR_WIDTH:0]    lvl;

  assign s_ready = (state != TWO) & wrst_n;
  assign push    = s_valid & s_ready;
  assign w_en    = (state != EMPTY) & ~full & wrst_n;
  assign pop     = w_en;
  assign w_data  = head_q;

  // head_q always holds the oldest word; tail_q is only meaningful in TWO
  always_comb begin
    state_nxt = state;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_nxt  = s_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = s_data;
        end else if (push) begin
          state_nxt = TWO;
          tail_nxt  = s_data;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt = ONE;
          head_nxt  = tail_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state  <= state_nxt;
      head_q <= head_nxt;
      tail_q <= tail_nxt;
    end
  end

  // Gray to binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      rbin[i] = ^(g_rptr_sync >> i);
    end
  end

  assign lvl = b_wptr - rbin;

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      wr_level    <= '0;
      almost_full <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      wr_level    <= lvl;
      almost_full <= (lvl >= AFULL_THRESH);
      if ((state != EMPTY) && full && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// tb/tb_wr_ingress_ctrl.sv - randomized and directed bench for wr_ingress_ctrl against a queue-based model
module tb_wr_ingress_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;
  localparam int AM = 2;

  logic          w_clk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          w_en;
  logic [DW-1:0] w_data;
  logic          full = 1'b0;
  logic [PW:0]   b_wptr = '0;
  logic [PW:0]   g_rptr_sync = '0;
  logic [PW:0]   wr_level;
  logic          almost_full;
  logic [15:0]   stall_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  wr_ingress_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .AFULL_MARGIN(AM)) dut (
    .w_clk(w_clk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .w_en(w_en), .w_data(w_data), .full(full), .b_wptr(b_wptr), .g_rptr_sync(g_rptr_sync),
    .wr_level(wr_level), .almost_full(almost_full), .stall_cnt(stall_cnt)
  );

  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // find the binary value whose Gray code matches
  function automatic int gray_to_bin(input logic [PW:0] g);
    for (int v = 0; v < (1 << (PW+1)); v++) begin
      if (((v ^ (v >> 1)) & ((1 << (PW+1)) - 1)) == int'(g)) return v;
    end
    return 0;
  endfunction

  // Reference model: word queue, level/flag one cycle behind the pointers, integer stall count
  logic [DW-1:0] mq[$];
  int  m_lvl = 0;
  bit  m_af = 0;
  int  m_stall = 0;
  bit  started = 0;

  always @(negedge w_clk) begin
    bit exp_sr;
    bit exp_we;
    int l;
    exp_sr = wrst_n && (mq.size() != 2);
    exp_we = wrst_n && (mq.size() != 0) && !full;
    if (started) begin
      chk("s_ready", 32'(s_ready), 32'(exp_sr));
      chk("w_en", 32'(w_en), 32'(exp_we));
      if (exp_we) chk("w_data", 32'(w_data), 32'(mq[0]));
      chk("wr_level", 32'(wr_level), 32'(m_lvl));
      chk("almost_full", 32'(almost_full), 32'(m_af));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end
    if (!wrst_n) begin
      mq.delete();
      m_lvl = 0;
      m_af = 0;
      m_stall = 0;
      started = 1;
    end else begin
      if (mq.size() != 0 && full && m_stall < 65535) m_stall++;
      if (exp_we) void'(mq.pop_front());
      if (s_valid && exp_sr) mq.push_back(s_data);
      l = (int'(b_wptr) - gray_to_bin(g_rptr_sync) + (1 << (PW+1))) % (1 << (PW+1));
      m_lvl = l;
      m_af = (l >= (1 << PW) - AM);
    end
  end

  task automatic tick(input logic rst, input logic v, input logic [DW-1:0] d, input logic f);
    @(posedge w_clk);
    #1;
    wrst_n = rst;
    s_valid = v;
    s_data = d;
    full = f;
    @(negedge w_clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got[$];
    int first_push;
    int first_wen;
    int last_wen;
    int ready_low;
    int next;
    int bad;
    int wen_seen;

    // reset with producer active
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h55, 1'b0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_w_en", 32'(w_en), 32'd0);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    chk("post_rst_level", 32'(wr_level), 32'd0);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);

    // streaming 0x01..0x10
    first_push = -1; first_wen = -1; last_wen = -1; ready_low = 0; next = 1;
    for (int k = 0; k < 40; k++) begin
      if (next <= 16) tick(1'b1, 1'b1, DW'(next), 1'b0);
      else tick(1'b1, 1'b0, 8'h00, 1'b0);
      if (w_en) begin
        got.push_back(w_data);
        if (first_wen < 0) first_wen = cyc;
        last_wen = cyc;
      end
      if (next <= 16) begin
        if (!s_ready) ready_low++;
        else begin
          if (first_push < 0) first_push = cyc;
          next++;
        end
      end
    end
    chk("stream_count", 32'(got.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] != DW'(i + 1)) bad++;
    chk("stream_order_errors", 32'(bad), 32'd0);
    chk("stream_latency", 32'(first_wen - first_push), 32'd1);
    chk("stream_span", 32'(last_wen - first_wen), 32'd15);
    chk("stream_ready_lows", 32'(ready_low), 32'd0);

    // backpressure: full for 5 cycles mid-stream
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b1, 8'hA1, 1'b0);
    tick(1'b1, 1'b1, 8'hA2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, DW'(8'hA3 + i), 1'b1);
      chk("bp_no_wen", 32'(w_en), 32'd0);
    end
    chk("bp_s_ready_low", 32'(s_ready), 32'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("bp_stall5", 32'(stall_cnt), 32'd5);
    chk("bp_release_wen", 32'(w_en), 32'd1);
    chk("bp_release_data", 32'(w_data), 32'hA2);
    chk("bp_release_ready", 32'(s_ready), 32'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("bp_second_data", 32'(w_data), 32'hA3);
    chk("bp_ready_recover", 32'(s_ready), 32'd1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("bp_drained_wen", 32'(w_en), 32'd0);

    // push+pop in ONE with irregular valid patterns
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, (i % 3 != 2) || (i % 7 == 5), DW'($urandom), 1'b0);
      chk("one_s_ready", 32'(s_ready), 32'd1);
    end

    // level and wrap
    @(posedge w_clk); #1; b_wptr = 4'b0010; g_rptr_sync = 4'b1010;
    @(negedge w_clk);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("level_wrap6", 32'(wr_level), 32'd6);
    chk("afull_at6", 32'(almost_full), 32'd1);
    @(posedge w_clk); #1; b_wptr = 4'b0001;
    @(negedge w_clk);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("level_wrap5", 32'(wr_level), 32'd5);
    chk("afull_at5", 32'(almost_full), 32'd0);

    // randomized traffic, pointers and occasional reset
    for (int i = 0; i < 3000; i++) begin
      @(posedge w_clk);
      #1;
      wrst_n = ($urandom_range(0, 199) != 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data = DW'($urandom);
      full = ($urandom_range(0, 9) < 3);
      b_wptr = (PW+1)'($urandom);
      g_rptr_sync = (PW+1)'($urandom);
      @(negedge w_clk);
    end

    // stall counter saturation with buffer held at TWO
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 8'hC1, 1'b1);
    tick(1'b1, 1'b1, 8'hC2, 1'b1);
    for (int i = 0; i < 65540; i++) begin
      tick(1'b1, 1'b1, 8'hC3, 1'b1);
    end
    chk("stall_saturated", 32'(stall_cnt), 32'hFFFF);
    chk("sat_s_ready_low", 32'(s_ready), 32'd0);

    // reset with two words buffered: they must vanish
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    wen_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      if (w_en) wen_seen++;
    end
    chk("rst_discard_no_wen", 32'(wen_seen), 32'd0);
    chk("rst_discard_stall", 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
